// File: rtl/fft_pkg.sv
// fft_pkg: shared sizing, FSM encodings, write-back record and bit-reversal helper for the FFT frame sequencer
package fft_pkg;
  localparam int N = 16;
  localparam int LOG2N = 4;
  localparam int BF_LAT = 2;
  localparam int SW = $clog2(LOG2N);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_DRAIN, S_OUT} state_t;
  typedef struct packed {
    logic             rd;
    logic [LOG2N-1:0] a;
    logic [LOG2N-1:0] b;
  } bf_op_t;
  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = x[LOG2N-1-i];
    return r;
  endfunction
endpackage

// File: rtl/fft_addr_gen.sv
// fft_addr_gen: maps stage s and butterfly b to DIF operand addresses and twiddle index
module fft_addr_gen
  import fft_pkg::*;
(
  input  logic [SW-1:0]    s,
  input  logic [LOG2N-2:0] b,
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b,
  output logic [LOG2N-2:0] tw
);
  localparam int TW = LOG2N - 1;
  logic [LOG2N-1:0] bx, span, low;
  always_comb begin
    bx = LOG2N'(b);
    span = LOG2N'(N / 2) >> s;
    low = bx & (span - LOG2N'(1));
    addr_a = ((bx >> (LOG2N - 1 - int'(s))) << (LOG2N - int'(s))) | low;
    addr_b = addr_a + span;
    tw = TW'(low << s);
  end
endmodule

// File: rtl/fft_frame_seq.sv
// fft_frame_seq: 16-point radix-2 DIF FFT frame sequencer: load, in-place butterflies, bit-reversed readout.
// Define FFT_SEQ_OVERRUN_EN to add the sticky oOVERRUN flag for start edges seen while busy.
module fft_frame_seq
  import fft_pkg::*;
(
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iStart_INT,
  input  logic             iCLR,
  input  logic             iDIN_VALID,
  output logic             oBUSY,
  output logic             oWR_EN,
  output logic [LOG2N-1:0] oWR_ADDR,
  output logic             oBF_RD,
  output logic [LOG2N-1:0] oADDR_A,
  output logic [LOG2N-1:0] oADDR_B,
  output logic [LOG2N-2:0] oTW_IDX,
  output logic [SW-1:0]    oSTAGE,
  output logic             oBF_WR,
  output logic [LOG2N-1:0] oWADDR_A,
  output logic [LOG2N-1:0] oWADDR_B,
  output logic [LOG2N-1:0] oRD_ADDR,
  output logic             oEN,
  output logic             oDONE
`ifdef FFT_SEQ_OVERRUN_EN
  ,
  output logic             oOVERRUN
`endif
);
  localparam int CW = LOG2N + 1;
  localparam int DW = $clog2(BF_LAT) + 1;
  state_t state;
  logic [CW-1:0] cnt;
  logic [SW-1:0] stage;
  logic [DW-1:0] dcnt;
  logic start_q, start_edge, calc, out;
  logic [LOG2N-1:0] ga, gb;
  logic [LOG2N-2:0] gt;
  bf_op_t cur;
  bf_op_t dl [BF_LAT];

  fft_addr_gen u_addr (
    .s(stage),
    .b(cnt[LOG2N-2:0]),
    .addr_a(ga),
    .addr_b(gb),
    .tw(gt)
  );

  always_comb begin
    start_edge = iStart_INT & ~start_q;
    calc = state == S_CALC;
    out = state == S_OUT;
    oBUSY = state != S_IDLE;
    oWR_EN = (state == S_LOAD) && iDIN_VALID;
    oWR_ADDR = state == S_LOAD ? cnt[LOG2N-1:0] : '0;
    oBF_RD = calc;
    oADDR_A = calc ? ga : '0;
    oADDR_B = calc ? gb : '0;
    oTW_IDX = calc ? gt : '0;
    oSTAGE = stage;
    cur = '{rd: calc, a: oADDR_A, b: oADDR_B};
    oBF_WR = dl[BF_LAT-1].rd;
    oWADDR_A = dl[BF_LAT-1].a;
    oWADDR_B = dl[BF_LAT-1].b;
    oRD_ADDR = out ? bitrev(cnt[LOG2N-1:0]) : '0;
  end

  // cnt is the load index, butterfly index and readout index in turn; cnt[LOG2N] marks the extra OUT cycle
  always_ff @(posedge iCLK) begin
    start_q <= iRST ? 1'b0 : iStart_INT;
    if (iRST || iCLR) begin
      state <= S_IDLE;
      cnt <= '0;
      stage <= '0;
      dcnt <= '0;
      oEN <= 1'b0;
      oDONE <= 1'b0;
      for (int i = 0; i < BF_LAT; i++) dl[i] <= '0;
    end else begin
      dl[0] <= cur;
      for (int i = 1; i < BF_LAT; i++) dl[i] <= dl[i-1];
      oEN <= out && !cnt[LOG2N];
      oDONE <= out && cnt == CW'(N - 1);
      case (state)
        S_IDLE: if (start_edge) begin
          state <= S_LOAD;
          cnt <= '0;
        end
        S_LOAD: if (iDIN_VALID) begin
          if (cnt == CW'(N - 1)) begin
            state <= S_CALC;
            cnt <= '0;
            stage <= '0;
          end else cnt <= cnt + CW'(1);
        end
        S_CALC: if (cnt == CW'(N / 2 - 1)) begin
          state <= S_DRAIN;
          cnt <= '0;
          dcnt <= '0;
        end else cnt <= cnt + CW'(1);
        S_DRAIN: if (dcnt == DW'(BF_LAT - 1)) begin
          dcnt <= '0;
          if (stage == SW'(LOG2N - 1)) state <= S_OUT;
          else begin
            stage <= stage + SW'(1);
            state <= S_CALC;
          end
        end else dcnt <= dcnt + DW'(1);
        S_OUT: if (cnt[LOG2N]) begin
          state <= S_IDLE;
          cnt <= '0;
          stage <= '0;
        end else cnt <= cnt + CW'(1);
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FFT_SEQ_OVERRUN_EN
  always_ff @(posedge iCLK)
    if (iRST) oOVERRUN <= 1'b0;
    else if (start_edge && state != S_IDLE) oOVERRUN <= 1'b1;
`endif
endmodule

// File: tb/tb_fft_frame_seq.sv
// tb_fft_frame_seq: directed self-checking bench for fft_frame_seq (frame timing, addressing, readout, clear, overrun)
module tb_fft_frame_seq;
  logic iCLK = 1'b0;
  logic iRST, iStart_INT, iCLR, iDIN_VALID;
  logic oBUSY, oWR_EN, oBF_RD, oBF_WR, oEN, oDONE;
  logic [3:0] oWR_ADDR, oADDR_A, oADDR_B, oWADDR_A, oWADDR_B, oRD_ADDR;
  logic [2:0] oTW_IDX;
  logic [1:0] oSTAGE;
`ifdef FFT_SEQ_OVERRUN_EN
  logic oOVERRUN;
`endif
  int checks = 0;
  int errors = 0;
  logic [3:0] rev [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  always #5 iCLK = ~iCLK;

  fft_frame_seq dut (
    .iCLK(iCLK),
    .iRST(iRST),
    .iStart_INT(iStart_INT),
    .iCLR(iCLR),
    .iDIN_VALID(iDIN_VALID),
    .oBUSY(oBUSY),
    .oWR_EN(oWR_EN),
    .oWR_ADDR(oWR_ADDR),
    .oBF_RD(oBF_RD),
    .oADDR_A(oADDR_A),
    .oADDR_B(oADDR_B),
    .oTW_IDX(oTW_IDX),
    .oSTAGE(oSTAGE),
    .oBF_WR(oBF_WR),
    .oWADDR_A(oWADDR_A),
    .oWADDR_B(oWADDR_B),
    .oRD_ADDR(oRD_ADDR),
    .oEN(oEN),
    .oDONE(oDONE)
`ifdef FFT_SEQ_OVERRUN_EN
    ,
    .oOVERRUN(oOVERRUN)
`endif
  );

  task automatic tick;
    @(posedge iCLK);
    #1;
  endtask

  task automatic test_reset;
    logic [34:0] v;
    iRST = 1; iCLR = 0; iStart_INT = 0; iDIN_VALID = 0;
    repeat (3) tick;
    #1;
    v = {oBUSY, oWR_EN, oWR_ADDR, oBF_RD, oADDR_A, oADDR_B, oTW_IDX, oSTAGE, oBF_WR,
         oWADDR_A, oWADDR_B, oRD_ADDR, oEN, oDONE};
    checks++;
    if (v !== '0) begin errors++; $display("FAIL reset_outputs got %h want 0", v); end
`ifdef FFT_SEQ_OVERRUN_EN
    checks++;
    if (oOVERRUN !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", oOVERRUN); end
`endif
    iRST = 0;
    repeat (2) tick;
    #1;
    checks++;
    if (oBUSY !== 1'b0) begin errors++; $display("FAIL reset_idle busy got %b want 0", oBUSY); end
  endtask

  // one gap-free frame; c counts clock edges after the start edge is raised
  task automatic test_frame(input bit ovr);
    logic rd_h [100];
    logic [3:0] a_h [100];
    logic [3:0] b_h [100];
    bit exp_rd, exp_wr;
    iStart_INT = 0; iDIN_VALID = 1;
    tick;
    iStart_INT = 1;
    for (int c = 1; c <= 80; c++) begin
      tick;
      iStart_INT = (c < 6) || (ovr && c >= 60 && c < 63);
      #1;
      rd_h[c] = oBF_RD; a_h[c] = oADDR_A; b_h[c] = oADDR_B;
      exp_rd = c >= 17 && c <= 56 && (c - 17) % 10 < 8;
      exp_wr = c >= 19 && c <= 58 && (c - 19) % 10 < 8;
      checks++;
      if (oBUSY !== (c <= 73)) begin errors++; $display("FAIL frame_busy c=%0d got %b want %b", c, oBUSY, c <= 73); end
      checks++;
      if (oWR_EN !== (c <= 16) || (c <= 16 && oWR_ADDR !== 4'(c - 1))) begin
        errors++; $display("FAIL frame_load c=%0d got en=%b addr=%0d want en=%b addr=%0d", c, oWR_EN, oWR_ADDR, c <= 16, c - 1);
      end
      checks++;
      if (oBF_RD !== exp_rd) begin errors++; $display("FAIL frame_bf_rd c=%0d got %b want %b", c, oBF_RD, exp_rd); end
      if (exp_rd) begin
        checks++;
        if (oSTAGE !== 2'((c - 17) / 10)) begin errors++; $display("FAIL frame_stage c=%0d got %0d want %0d", c, oSTAGE, (c - 17) / 10); end
      end
      checks++;
      if (oBF_WR !== exp_wr) begin errors++; $display("FAIL frame_bf_wr c=%0d got %b want %b", c, oBF_WR, exp_wr); end
      if (exp_wr) begin
        checks++;
        if (rd_h[c-2] !== 1'b1 || oWADDR_A !== a_h[c-2] || oWADDR_B !== b_h[c-2]) begin
          errors++; $display("FAIL frame_wb_addr c=%0d got %0d/%0d want %0d/%0d", c, oWADDR_A, oWADDR_B, a_h[c-2], b_h[c-2]);
        end
      end
      if (c == 20 || c == 32 || c == 38 || c == 53) begin
        logic [10:0] want;
        want = c == 20 ? {4'd3, 4'd11, 3'd3} : c == 32 ? {4'd9, 4'd13, 3'd2} :
               c == 38 ? {4'd1, 4'd3, 3'd4} : {4'd12, 4'd13, 3'd0};
        checks++;
        if ({oADDR_A, oADDR_B, oTW_IDX} !== want) begin
          errors++; $display("FAIL frame_addr c=%0d got A=%0d B=%0d tw=%0d want A=%0d B=%0d tw=%0d",
                             c, oADDR_A, oADDR_B, oTW_IDX, want[10:7], want[6:3], want[2:0]);
        end
      end
      if (c == 55) begin
        checks++;
        if ({oBF_WR, oWADDR_A, oWADDR_B} !== {1'b1, 4'd12, 4'd13}) begin
          errors++; $display("FAIL frame_last_wb got %b %0d %0d want 1 12 13", oBF_WR, oWADDR_A, oWADDR_B);
        end
      end
      if (c >= 57 && c <= 72) begin
        checks++;
        if (oRD_ADDR !== rev[c-57]) begin errors++; $display("FAIL frame_rd_addr k=%0d got %0d want %0d", c - 57, oRD_ADDR, rev[c-57]); end
      end
      checks++;
      if (oEN !== (c >= 58 && c <= 73)) begin errors++; $display("FAIL frame_en c=%0d got %b want %b", c, oEN, c >= 58 && c <= 73); end
      checks++;
      if (oDONE !== (c == 73)) begin errors++; $display("FAIL frame_done c=%0d got %b want %b", c, oDONE, c == 73); end
`ifdef FFT_SEQ_OVERRUN_EN
      if (ovr && (c == 60 || c == 61)) begin
        checks++;
        if (oOVERRUN !== (c == 61)) begin errors++; $display("FAIL frame_overrun c=%0d got %b want %b", c, oOVERRUN, c == 61); end
      end
`endif
    end
    iStart_INT = 0;
`ifdef FFT_SEQ_OVERRUN_EN
    checks++;
    if (oOVERRUN !== ovr) begin errors++; $display("FAIL frame_overrun_end got %b want %b", oOVERRUN, ovr); end
`endif
  endtask

  task automatic test_gaps;
    int wr = 0;
    iStart_INT = 0; iDIN_VALID = 0;
    tick;
    iStart_INT = 1;
    for (int c = 1; c <= 95; c++) begin
      tick;
      iDIN_VALID = (c % 2 == 1);
      #1;
      if (oWR_EN) begin
        checks++;
        if (oWR_ADDR !== 4'(wr)) begin errors++; $display("FAIL gaps_addr c=%0d got %0d want %0d", c, oWR_ADDR, wr); end
        wr++;
      end
      checks++;
      if (oWR_EN !== (c <= 31 && c % 2 == 1)) begin errors++; $display("FAIL gaps_wr_en c=%0d got %b want %b", c, oWR_EN, c <= 31 && c % 2 == 1); end
      if (c <= 39) begin
        checks++;
        if (oBF_RD !== (c >= 32)) begin errors++; $display("FAIL gaps_calc_start c=%0d got %b want %b", c, oBF_RD, c >= 32); end
      end
      checks++;
      if (oDONE !== (c == 88)) begin errors++; $display("FAIL gaps_done c=%0d got %b want %b", c, oDONE, c == 88); end
    end
    checks++;
    if (wr !== 16) begin errors++; $display("FAIL gaps_count got %0d want 16", wr); end
    iStart_INT = 0; iDIN_VALID = 0;
  endtask

  task automatic test_clr;
    iStart_INT = 0; iDIN_VALID = 1;
    tick;
    iStart_INT = 1;
    repeat (40) tick;
    #1;
    checks++;
    if (oSTAGE !== 2'd2 || oBF_RD !== 1'b1) begin errors++; $display("FAIL clr_pre got stage=%0d rd=%b want 2 1", oSTAGE, oBF_RD); end
    iCLR = 1;
    tick;
    iCLR = 0;
    #1;
    checks++;
    if (oBUSY !== 1'b0 || oSTAGE !== 2'd0) begin errors++; $display("FAIL clr_idle got busy=%b stage=%0d want 0 0", oBUSY, oSTAGE); end
    for (int c = 0; c < 20; c++) begin
      checks++;
      if ({oBF_WR, oEN, oDONE, oBUSY, oBF_RD} !== 5'b0) begin
        errors++; $display("FAIL clr_quiet c=%0d got wr=%b en=%b done=%b busy=%b rd=%b want 0", c, oBF_WR, oEN, oDONE, oBUSY, oBF_RD);
      end
      tick;
      #1;
    end
    iStart_INT = 0;
    tick;
    iStart_INT = 1; iCLR = 1;
    tick;
    iCLR = 0;
    #1;
    checks++;
    if (oBUSY !== 1'b0) begin errors++; $display("FAIL clr_vs_start got busy=%b want 0", oBUSY); end
    repeat (3) tick;
    #1;
    checks++;
    if (oBUSY !== 1'b0) begin errors++; $display("FAIL clr_vs_start_later got busy=%b want 0", oBUSY); end
    iStart_INT = 0; iDIN_VALID = 0;
  endtask

`ifdef FFT_SEQ_OVERRUN_EN
  task automatic test_overrun;
    iCLR = 1;
    tick;
    iCLR = 0;
    #1;
    checks++;
    if (oOVERRUN !== 1'b1) begin errors++; $display("FAIL overrun_after_clr got %b want 1", oOVERRUN); end
    iRST = 1;
    tick;
    iRST = 0;
    #1;
    checks++;
    if (oOVERRUN !== 1'b0) begin errors++; $display("FAIL overrun_after_rst got %b want 0", oOVERRUN); end
  endtask
`endif

  initial begin
    test_reset;
    test_frame(0);
    test_gaps;
    test_clr;
    test_frame(0);
    test_frame(1);
`ifdef FFT_SEQ_OVERRUN_EN
    test_overrun;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
